// File: rtl/mem_arbiter_if.sv
// Bundles both requester ports and the shared memory connection of mem_arbiter.
interface mem_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             a_req;
    logic             b_req;
    logic             a_we;
    logic             b_we;
    logic             a_lock;
    logic             b_lock;
    logic [WIDTH-1:0] a_addr;
    logic [WIDTH-1:0] b_addr;
    logic [15:0]      a_wdata;
    logic [15:0]      b_wdata;
    logic             a_gnt;
    logic             b_gnt;
    logic [15:0]      a_rdata;
    logic [15:0]      b_rdata;
    logic             a_rvalid;
    logic             b_rvalid;
    logic             mem_write_enable;
    logic [WIDTH-1:0] mem_read_address;
    logic [WIDTH-1:0] mem_write_address;
    logic [15:0]      mem_data_in;
    logic [15:0]      mem_data_out;

    // Arbiter side.
    modport slave (
        input  a_req, b_req, a_we, b_we, a_lock, b_lock,
        input  a_addr, b_addr, a_wdata, b_wdata,
        input  mem_data_out,
        output a_gnt, b_gnt, a_rdata, b_rdata, a_rvalid, b_rvalid,
        output mem_write_enable, mem_read_address, mem_write_address, mem_data_in
    );

    // Requesters plus memory side.
    modport master (
        output a_req, b_req, a_we, b_we, a_lock, b_lock,
        output a_addr, b_addr, a_wdata, b_wdata,
        output mem_data_out,
        input  a_gnt, b_gnt, a_rdata, b_rdata, a_rvalid, b_rvalid,
        input  mem_write_enable, mem_read_address, mem_write_address, mem_data_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter with bounded lock in front of one synchronous memory.
// Port A is instruction fetch, port B is data load/store; read data returns one
// cycle after the grant to the port that issued the read.
module mem_arbiter #(
    parameter int WIDTH    = 8,
    parameter int LOCK_MAX = 4
) (
    input logic          clock,
    input logic          reset_n,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_A    = 2'd1,
        SRC_B    = 2'd2
    } src_t;

    localparam logic [4:0] LOCK_LIMIT = 5'(LOCK_MAX);

    logic             prio;
    src_t             lock_owner;
    logic [3:0]       lock_cnt;
    src_t             rd_tag;

    logic             grant_a;
    logic             grant_b;
    logic [WIDTH-1:0] sel_addr;
    logic [15:0]      sel_wdata;
    logic             sel_we;
    logic [4:0]       run_a;
    logic [4:0]       run_b;

    // Grant selection: live lock owner first, then single requester, then prio.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset_n) begin
            grant_a = 1'b0;
            grant_b = 1'b0;
        end else if (lock_owner == SRC_A && bus.a_req) begin
            grant_a = 1'b1;
        end else if (lock_owner == SRC_B && bus.b_req) begin
            grant_b = 1'b1;
        end else if (bus.a_req && bus.b_req) begin
            grant_a = ~prio;
            grant_b = prio;
        end else if (bus.a_req) begin
            grant_a = 1'b1;
        end else if (bus.b_req) begin
            grant_b = 1'b1;
        end
    end

    // Route the granted port onto the memory; idle drives zeros.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        if (grant_a) begin
            sel_addr  = bus.a_addr;
            sel_wdata = bus.a_wdata;
            sel_we    = bus.a_we;
        end else if (grant_b) begin
            sel_addr  = bus.b_addr;
            sel_wdata = bus.b_wdata;
            sel_we    = bus.b_we;
        end
    end

    // Length of the locked run if this cycle's grant extends it. Releasing when the
    // run reaches LOCK_MAX equals releasing at lock_cnt == LOCK_MAX-1 for an
    // established owner, and also keeps LOCK_MAX = 1 from holding forever.
    always_comb begin
        run_a = (lock_owner == SRC_A) ? ({1'b0, lock_cnt} + 5'd1) : 5'd1;
        run_b = (lock_owner == SRC_B) ? ({1'b0, lock_cnt} + 5'd1) : 5'd1;
    end

    // Arbitration state: round-robin pointer, lock tracking and read return tag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio       <= 1'b0;
            lock_owner <= SRC_NONE;
            lock_cnt   <= '0;
            rd_tag     <= SRC_NONE;
        end else begin
            if (grant_a && !bus.a_we) begin
                rd_tag <= SRC_A;
            end else if (grant_b && !bus.b_we) begin
                rd_tag <= SRC_B;
            end else begin
                rd_tag <= SRC_NONE;
            end

            if (grant_a) begin
                prio <= 1'b1;
                if (bus.a_lock && run_a < LOCK_LIMIT) begin
                    lock_owner <= SRC_A;
                    lock_cnt   <= run_a[3:0];
                end else begin
                    lock_owner <= SRC_NONE;
                    lock_cnt   <= '0;
                end
            end else if (grant_b) begin
                prio <= 1'b0;
                if (bus.b_lock && run_b < LOCK_LIMIT) begin
                    lock_owner <= SRC_B;
                    lock_cnt   <= run_b[3:0];
                end else begin
                    lock_owner <= SRC_NONE;
                    lock_cnt   <= '0;
                end
            end else begin
                lock_owner <= SRC_NONE;
                lock_cnt   <= '0;
            end
        end
    end

    assign bus.a_gnt             = grant_a;
    assign bus.b_gnt             = grant_b;
    assign bus.mem_write_enable  = sel_we;
    assign bus.mem_read_address  = sel_addr;
    assign bus.mem_write_address = sel_addr;
    assign bus.mem_data_in       = sel_wdata;
    assign bus.a_rvalid          = (rd_tag == SRC_A);
    assign bus.b_rvalid          = (rd_tag == SRC_B);
    assign bus.a_rdata           = bus.mem_data_out;
    assign bus.b_rdata           = bus.mem_data_out;

endmodule
